// File: rtl/lcd_spi_pkg.sv
// -----------------------------------------------------------------------------
// lcd_spi_pkg
// Shared definitions for the LCD SPI path: serializer state encoding, panel
// command bytes and RGB565 colour words used by the upstream sequencer.
// No ports (package).
// -----------------------------------------------------------------------------
package lcd_spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        GAP   = 3'd4,
        HOLD  = 3'd5
    } state_t;

    // Panel command bytes
    localparam logic [7:0] SLPOUT     = 8'h11;
    localparam logic [7:0] DISPON     = 8'h29;
    localparam logic [7:0] COLMOD     = 8'h3A;
    localparam logic [7:0] COLMOD_565 = 8'h55;
    localparam logic [7:0] RAMWR      = 8'h2C;

    // RGB565 colours
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE  = 16'h001F;
    localparam logic [15:0] BLACK = 16'h0000;

endpackage

// File: rtl/spi_byte_tx_if.sv
// -----------------------------------------------------------------------------
// spi_byte_tx_if
// Byte handshake between the LCD sequencer (master) and the SPI serializer
// (slave).
//   tx_valid : master -> slave, tx_data/tx_dc valid
//   tx_ready : slave -> master, byte can be accepted this cycle
//   tx_data  : master -> slave, byte to send, MSB first
//   tx_dc    : master -> slave, D/C flag (0 = command, 1 = data)
// -----------------------------------------------------------------------------
interface spi_byte_tx_if;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_dc;

    modport master (
        output tx_valid,
        output tx_data,
        output tx_dc,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  tx_dc,
        output tx_ready
    );

endinterface

// File: rtl/spi_half_period_ctr.sv
// -----------------------------------------------------------------------------
// spi_half_period_ctr
// Counts clk cycles within one scl half-period (or setup / hold interval).
//   clk   : system clock
//   reset : synchronous, active-high
//   clear : restart the interval from 0 on the next edge
//   tc    : high in the last cycle of a CLK_DIV-cycle interval
// -----------------------------------------------------------------------------
module spi_half_period_ctr #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tc
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_byte_tx.sv
// -----------------------------------------------------------------------------
// spi_byte_tx
// SPI mode-0 byte serializer for the LCD panel. Accepts one byte plus D/C flag
// per handshake and shifts it MSB-first on scl/sda, framing with active-low cs.
// cs stays low between bytes while en=1.
//   clk   : system clock
//   reset : synchronous, active-high
//   en    : burst enable, sampled only between bytes
//   bus   : byte handshake (slave side)
//   cs    : chip select, active low
//   scl   : serial clock, idles low
//   sda   : serial data, changes only while scl is low
//   dc    : D/C flag of the byte on the wire
//   done  : one-cycle pulse after the last bit's high phase
//   busy  : high in SETUP/HIGH/LOW/HOLD
// -----------------------------------------------------------------------------
module spi_byte_tx
    import lcd_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    spi_byte_tx_if.slave bus,
    output logic         cs,
    output logic         scl,
    output logic         sda,
    output logic         dc,
    output logic         done,
    output logic         busy
);

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       hp_tc;
    logic       hp_clear;

    // Remaining bits after the one currently on sda; bit 6 is next out.
    logic [6:0] shreg;
    logic [6:0] shreg_nxt;
    logic [2:0] bitcnt;
    logic [2:0] bitcnt_nxt;

    logic       cs_nxt;
    logic       scl_nxt;
    logic       sda_nxt;
    logic       dc_nxt;
    logic       done_nxt;
    logic       busy_nxt;

    assign bus.tx_ready = ~reset & ((state == IDLE) | (state == GAP));
    assign accept       = bus.tx_valid & bus.tx_ready;

    // Interval counter restarts on every state change and sits at 0 while
    // waiting for a byte, so each timed state gets a full CLK_DIV cycles.
    assign hp_clear = (state_nxt != state) | (state == IDLE) | (state == GAP);

    spi_half_period_ctr #(
        .CLK_DIV(CLK_DIV)
    ) u_hp_ctr (
        .clk   (clk),
        .reset (reset),
        .clear (hp_clear),
        .tc    (hp_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (hp_tc) state_nxt = HIGH;
            HIGH:    if (hp_tc) state_nxt = (bitcnt == 3'd7) ? GAP : LOW;
            LOW:     if (hp_tc) state_nxt = HIGH;
            // A new byte wins over a simultaneous en=0.
            GAP: begin
                if (accept)   state_nxt = SETUP;
                else if (!en) state_nxt = HOLD;
            end
            HOLD:    if (hp_tc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cs_nxt     = cs;
        scl_nxt    = scl;
        sda_nxt    = sda;
        dc_nxt     = dc;
        done_nxt   = 1'b0;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        busy_nxt   = (state_nxt == SETUP) | (state_nxt == HIGH) |
                     (state_nxt == LOW)   | (state_nxt == HOLD);
        case (state)
            IDLE, GAP: begin
                if (accept) begin
                    shreg_nxt  = bus.tx_data[6:0];
                    sda_nxt    = bus.tx_data[7];
                    dc_nxt     = bus.tx_dc;
                    cs_nxt     = 1'b0;
                    scl_nxt    = 1'b0;
                    bitcnt_nxt = 3'd0;
                end
            end
            SETUP: begin
                if (hp_tc) scl_nxt = 1'b1;
            end
            HIGH: begin
                if (hp_tc) begin
                    scl_nxt = 1'b0;
                    if (bitcnt == 3'd7) begin
                        done_nxt = 1'b1;
                    end else begin
                        sda_nxt    = shreg[6];
                        shreg_nxt  = {shreg[5:0], 1'b0};
                        bitcnt_nxt = bitcnt + 3'd1;
                    end
                end
            end
            LOW: begin
                if (hp_tc) scl_nxt = 1'b1;
            end
            HOLD: begin
                if (hp_tc) cs_nxt = 1'b1;
            end
            default: begin
                cs_nxt  = 1'b1;
                scl_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs     <= 1'b1;
            scl    <= 1'b0;
            sda    <= 1'b0;
            dc     <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            shreg  <= '0;
            bitcnt <= '0;
        end else begin
            cs     <= cs_nxt;
            scl    <= scl_nxt;
            sda    <= sda_nxt;
            dc     <= dc_nxt;
            done   <= done_nxt;
            busy   <= busy_nxt;
            shreg  <= shreg_nxt;
            bitcnt <= bitcnt_nxt;
        end
    end

endmodule

// File: tb/tb_spi_byte_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_tx
// Bench for spi_byte_tx: one instance with CLK_DIV=1 and one with CLK_DIV=2,
// selected by 'sel'. Expected waveforms come from the timing rules of the
// serializer (first rise at 1+D, alternating D-cycle halves, done at 16D+1,
// cs released at 17D+2 when en=0).
// -----------------------------------------------------------------------------
module tb_spi_byte_tx;
    import lcd_spi_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_dc = 1'b0;
    logic [7:0] tx_data = 8'h00;
    int         sel = 2;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    spi_byte_tx_if bus1();
    spi_byte_tx_if bus2();

    logic cs1, scl1, sda1, dc1, done1, busy1;
    logic cs2, scl2, sda2, dc2, done2, busy2;

    assign bus1.tx_valid = tx_valid & (sel == 1);
    assign bus1.tx_data  = tx_data;
    assign bus1.tx_dc    = tx_dc;
    assign bus2.tx_valid = tx_valid & (sel == 2);
    assign bus2.tx_data  = tx_data;
    assign bus2.tx_dc    = tx_dc;

    spi_byte_tx #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .bus(bus1),
        .cs(cs1), .scl(scl1), .sda(sda1), .dc(dc1), .done(done1), .busy(busy1)
    );

    spi_byte_tx #(.CLK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .bus(bus2),
        .cs(cs2), .scl(scl2), .sda(sda2), .dc(dc2), .done(done2), .busy(busy2)
    );

    logic o_cs, o_scl, o_sda, o_dc, o_done, o_busy, o_ready;
    assign o_cs    = (sel == 1) ? cs1   : cs2;
    assign o_scl   = (sel == 1) ? scl1  : scl2;
    assign o_sda   = (sel == 1) ? sda1  : sda2;
    assign o_dc    = (sel == 1) ? dc1   : dc2;
    assign o_done  = (sel == 1) ? done1 : done2;
    assign o_busy  = (sel == 1) ? busy1 : busy2;
    assign o_ready = (sel == 1) ? bus1.tx_ready : bus2.tx_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Sends one byte on the selected instance and checks every cycle from
    // accept+1 to the done cycle against the expected waveform.
    task automatic send(input logic [7:0] d, input logic dcf, input bit keep,
                        input logic en_after);
        int         dv;
        int         n;
        int         phase;
        int         rises;
        logic       prev;
        logic       e_scl;
        logic       e_busy;
        logic [7:0] bits;
        dv = (sel == 1) ? 1 : 2;
        n  = 0;
        while (!o_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_accept", o_ready, 1);
        tx_data  = d;
        tx_dc    = dcf;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        en = en_after;
        if (!keep) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
            tx_dc    = 1'($urandom);
        end
        prev  = 1'b0;
        rises = 0;
        bits  = 8'h00;
        for (int k = 1; k <= 16 * dv + 1; k++) begin
            @(negedge clk);
            phase  = k - 1 - dv;
            e_scl  = (phase >= 0) && (phase < 15 * dv) && (((phase / dv) % 2) == 0);
            e_busy = (k <= 16 * dv);
            chk($sformatf("scl@%0d", k), o_scl, e_scl);
            chk($sformatf("cs@%0d", k), o_cs, 0);
            chk($sformatf("done@%0d", k), o_done, (k == 16 * dv + 1));
            chk($sformatf("busy@%0d", k), o_busy, e_busy);
            chk($sformatf("ready@%0d", k), o_ready, !e_busy);
            chk($sformatf("dc@%0d", k), o_dc, dcf);
            if (o_scl === 1'b1 && prev === 1'b0) begin
                rises++;
                bits = {bits[6:0], o_sda};
            end
            prev = o_scl;
        end
        chk("scl_rises", rises, 8);
        chk("sda_bits", bits, d);
    endtask

    // After a byte's done cycle with en=0: HOLD for D cycles, then cs high.
    task automatic release_cs();
        int dv;
        dv = (sel == 1) ? 1 : 2;
        for (int k = 16 * dv + 2; k <= 17 * dv + 2; k++) begin
            @(negedge clk);
            chk($sformatf("rel_cs@%0d", k), o_cs, (k > 17 * dv + 1));
            chk($sformatf("rel_busy@%0d", k), o_busy, (k <= 17 * dv + 1));
            chk($sformatf("rel_ready@%0d", k), o_ready, (k > 17 * dv + 1));
            chk($sformatf("rel_scl@%0d", k), o_scl, 0);
        end
    endtask

    initial begin
        int         n;
        int         rises;
        logic       prev;
        logic [7:0] d;
        logic       dcf;
        logic       e0;
        logic       e1;
        logic [15:0] c16;
        logic [7:0] tbl [6];

        c16    = GREEN;
        tbl[0] = DISPON;
        tbl[1] = COLMOD;
        tbl[2] = COLMOD_565;
        tbl[3] = c16[15:8];
        c16    = BLUE;
        tbl[4] = c16[7:0];
        c16    = BLACK;
        tbl[5] = c16[7:0];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", {cs1, cs2}, 2'b11);
        chk("rst_scl", {scl1, scl2}, 2'b00);
        chk("rst_sda", {sda1, sda2}, 2'b00);
        chk("rst_dc", {dc1, dc2}, 2'b00);
        chk("rst_done", {done1, done2}, 2'b00);
        chk("rst_busy", {busy1, busy2}, 2'b00);
        chk("rst_ready", {bus1.tx_ready, bus2.tx_ready}, 2'b00);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {bus1.tx_ready, bus2.tx_ready}, 2'b11);

        // Single byte, D=2, en=0
        sel = 2;
        en  = 1'b0;
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        release_cs();

        // Burst of three bytes, en drops during the last one
        en = 1'b1;
        c16 = RED;
        send(RAMWR, 1'b0, 1'b0, 1'b1);
        send(c16[15:8], 1'b1, 1'b0, 1'b1);
        send(c16[7:0], 1'b1, 1'b0, 1'b0);
        release_cs();

        // tx_valid held high with 8'hFF; en falls together with second accept
        en = 1'b1;
        send(8'hFF, 1'b1, 1'b1, 1'b1);
        en = 1'b0;
        send(8'hFF, 1'b1, 1'b0, 1'b0);
        release_cs();

        // Reset mid-byte after the third scl rise
        n = 0;
        while (!o_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        tx_data  = 8'hA5;
        tx_dc    = 1'b1;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        prev  = 1'b0;
        rises = 0;
        n     = 0;
        while (rises < 3 && n < 100) begin
            @(negedge clk);
            if (o_scl === 1'b1 && prev === 1'b0) rises++;
            prev = o_scl;
            n++;
        end
        chk("rises_before_reset", rises, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_cs", o_cs, 1);
        chk("midrst_scl", o_scl, 0);
        chk("midrst_sda", o_sda, 0);
        chk("midrst_dc", o_dc, 0);
        chk("midrst_done", o_done, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_ready", o_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", o_ready, 1);
        send(SLPOUT, 1'b0, 1'b0, 1'b0);
        release_cs();

        // D=1: single byte, then accept-vs-en priority
        sel = 1;
        en  = 1'b0;
        send(8'h55, 1'b0, 1'b0, 1'b0);
        release_cs();
        en = 1'b1;
        send(COLMOD, 1'b0, 1'b0, 1'b1);
        en = 1'b0;
        send(COLMOD_565, 1'b1, 1'b0, 1'b0);
        release_cs();

        // Randomized bytes across both dividers
        for (int i = 0; i < 10; i++) begin
            sel = ($urandom_range(0, 1) == 0) ? 1 : 2;
            d   = ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 5)] : 8'($urandom);
            dcf = 1'($urandom);
            e0  = 1'($urandom);
            e1  = 1'($urandom);
            en  = e0;
            send(d, dcf, 1'b0, e1);
            if (!e1) release_cs();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
